// File: rtl/full_adder_serial_ctrl.sv
// ----------------------------------------------------------------------------
// full_adder_serial_ctrl
//
// Bit-serial adder sequencer. A single 1-bit full-adder slice
// (sum = a^b^cin, carry = majority(a,b,cin)) is time-shared across a WIDTH-bit
// operand pair, LSB first, one bit per clock. Operands are captured on an
// accepted start. The slice is stepped WIDTH times through shift registers and
// a carry flop. The registered result is then presented together with a
// one-cycle done pulse. This is the area-minimal alternative to the
// combinational full adder.
//
// Timing: start accepted at edge k -> busy high for the WIDTH cycles after
// edges k..k+WIDTH-1 -> done high for the cycle after edge k+WIDTH. The next
// start can be accepted at edge k+WIDTH+2.
//
// Optional build macro:
//   FULL_ADDER_SERIAL_SUB_EN - adds the sub_in port. When sub_in=1 the block
//                              computes a - b, using b' = ~b and carry-in = 1.
//                              cout_out=1 then means no borrow. Without the
//                              macro the block is add-only.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset
//   start     in   1      operation request, sampled only in IDLE
//   a_in      in   WIDTH  operand A, captured on accepted start
//   b_in      in   WIDTH  operand B, captured on accepted start
//   cin_in    in   1      carry-in, captured on accepted start
//   sub_in    in   1      (FULL_ADDER_SERIAL_SUB_EN only) subtract select
//   busy      out  1      high while bits are being processed (RUN)
//   done      out  1      one-cycle result-valid pulse (DONE)
//   sum_out   out  WIDTH  registered sum, held until the next completion
//   cout_out  out  1      registered final carry, held with sum_out
// ----------------------------------------------------------------------------
module full_adder_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef FULL_ADDER_SERIAL_SUB_EN
    input  logic             sub_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    // Bit counter width is derived from WIDTH and is never overridden.
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Operand values presented to the shift registers on an accepted start.
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef FULL_ADDER_SERIAL_SUB_EN
    // Two's-complement subtract: a + ~b + 1. cin_in is ignored in this mode.
    always_comb begin
        b_load     = b_in;
        carry_load = cin_in;
        if (sub_in) begin
            b_load     = ~b_in;
            carry_load = 1'b1;
        end
    end
`else
    always_comb begin
        b_load     = b_in;
        carry_load = cin_in;
    end
`endif

    // Shared full-adder slice operating on the current LSBs.
    logic slice_sum;
    logic slice_carry;

    always_comb begin
        slice_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        slice_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // New sum bit enters at the MSB, so after WIDTH steps bit 0 holds the LSB.
    // Written with shifts rather than a part-select so that WIDTH=1 is legal.
    logic [WIDTH-1:0] sum_next;
    logic             last_bit;

    always_comb begin
        sum_next = (sum_sh >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));
        last_bit = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry  <= slice_carry;
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // Publish the result only here, so it holds through the next RUN.
                        sum_out  <= sum_next;
                        cout_out <= slice_carry;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Both are pure decodes of the state register, so neither has a path from an input.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_full_adder_serial_ctrl.sv
module tb_full_adder_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
`ifdef FULL_ADDER_SERIAL_SUB_EN
    logic         sub_in;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;

    int checks = 0;
    int errors = 0;

    // Model of the registered result the DUT should currently hold.
    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;

    full_adder_serial_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
`ifdef FULL_ADDER_SERIAL_SUB_EN
        .sub_in   (sub_in),
`endif
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: plain integer add / subtract on the operand values.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = W'(a - b);
            r[W]     = (a >= b);
        end else begin
            r = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom);
`ifdef FULL_ADDER_SERIAL_SUB_EN
        sub_in = 1'($urandom);
`endif
    endtask

    // Issue one operation from IDLE and follow it to the IDLE cycle after done.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic sub, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input bit scramble, input bit hold_start);
        int cycles;
        a_in   = a;
        b_in   = b;
        cin_in = c;
`ifdef FULL_ADDER_SERIAL_SUB_EN
        sub_in = sub;
`else
        if (sub) $display("note: %s requests subtract in an add-only build", name);
`endif
        start  = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < int'(W) + 4) begin
            checks++;
            if (sum_out !== held_sum || cout_out !== held_cout) begin
                errors++;
                $display("FAIL %s held_result: got %h/%b required %h/%b", name, sum_out,
                         cout_out, held_sum, held_cout);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_in_run: got %b required 0", name, done);
            end
            if (scramble) scramble_inputs();
            tick();
            cycles++;
        end
        checks++;
        if (cycles != int'(W)) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, cycles, W);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: got %b required 1", name, done);
        end
        checks++;
        if (sum_out !== exp_sum || cout_out !== exp_cout) begin
            errors++;
            $display("FAIL %s result: got %h/%b required %h/%b", name, sum_out, cout_out,
                     exp_sum, exp_cout);
        end
        held_sum  = exp_sum;
        held_cout = exp_cout;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after_done: got done=%b busy=%b required 0/0", name, done,
                     busy);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
`ifdef FULL_ADDER_SERIAL_SUB_EN
        sub_in = 1'b0;
`endif
        repeat (3) tick();
        rst       = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 || cout_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got busy=%b done=%b sum=%h cout=%b required 0/0/00/0",
                         i, busy, done, sum_out, cout_out);
            end
            tick();
        end
    endtask

    task automatic test_basic();
        run_op("basic_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_carry();
        run_op("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("wrap_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("cin_only", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic         c2;
        logic [W:0]   e2;
        a2 = W'($urandom);
        b2 = W'($urandom);
        c2 = 1'($urandom);
        e2 = model(a2, b2, c2, 1'b0);
        // First op keeps start high and sees its inputs churn while it runs.
        run_op("b2b_first", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b1, 1'b1);
        // run_op is now in the single IDLE cycle with start still high.
        run_op("b2b_second", a2, b2, c2, 1'b0, e2[W-1:0], e2[W], 1'b1, 1'b0);
        start = 1'b0;
    endtask

    task automatic test_abort();
        a_in   = 8'hAA;
        b_in   = 8'h55;
        cin_in = 1'b0;
`ifdef FULL_ADDER_SERIAL_SUB_EN
        sub_in = 1'b0;
`endif
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_run4_busy: got %b required 1", busy);
        end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 || cout_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_run_cleared: got busy=%b done=%b sum=%h cout=%b required 0/0/00/0",
                     busy, done, sum_out, cout_out);
        end
        for (int i = 0; i < int'(W) + 2; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done[%0d]: got done=%b busy=%b required 0/0", i, done,
                         busy);
            end
        end
        run_op("after_abort", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Reset landing in DONE must zero the just-published result.
        a_in   = 8'h80;
        b_in   = 8'h80;
        cin_in = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (W) tick();
        checks++;
        if (done !== 1'b1 || sum_out !== 8'h01 || cout_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_done_pre: got done=%b sum=%h cout=%b required 1/01/1", done,
                     sum_out, cout_out);
        end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 || cout_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_cleared: got busy=%b done=%b sum=%h cout=%b required 0/0/00/0",
                     busy, done, sum_out, cout_out);
        end
    endtask

`ifdef FULL_ADDER_SERIAL_SUB_EN
    task automatic test_sub();
        run_op("sub_10_03", 8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0);
        run_op("sub_03_10", 8'h03, 8'h10, 1'b1, 1'b1, 8'hF3, 1'b0, 1'b0, 1'b0);
        run_op("sub0_add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W:0]   e;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
`ifdef FULL_ADDER_SERIAL_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            e = model(a, b, c, s);
            run_op("random", a, b, c, s, e[W-1:0], e[W], (i % 2) == 1, 1'b0);
            if ((i % 3) == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_abort();
`ifdef FULL_ADDER_SERIAL_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
